// File: rtl/ramio_pkg.sv
// Shared definitions for the RAM/UART/LED port-A arbiter.
//   - access-size codes for write enables (we) and read enables (re)
//   - default data/address widths and the byte-address width helper
package ramio_pkg;

    // Write-enable codes (2 bits)
    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

    // Read-enable codes (3 bits): [2] sign-extend, [1:0] access size
    localparam logic [1:0] RE_NONE = 2'b00;
    localparam logic [1:0] RE_BYTE = 2'b01;
    localparam logic [1:0] RE_HALF = 2'b10;
    localparam logic [1:0] RE_WORD = 2'b11;
    localparam int         RE_SIGN_BIT = 2;

    // Default widths
    localparam int RAMIO_DATA_WIDTH = 32;
    localparam int RAMIO_ADDR_WIDTH = 16;

    // Word-address exponent -> byte-address width
    function automatic int byte_addr_width(input int word_addr_width);
        return word_addr_width + 2;
    endfunction

endpackage

// File: rtl/ramio_arb_core.sv
// Grant decision and starvation counter for the two-master port-A arbiter.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_m0_req, i_m1_req    requests from M0 (priority) and M1
//   o_m0_gnt, o_m1_gnt    combinational one-hot (or zero) grants
//
// Handshake: a master raises req and holds its fields stable; the cycle in
// which gnt is high is the cycle its access is presented to the I/O block.
// req may drop or change after that rising edge.
module ramio_arb_core #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_m0_req,
    input  logic i_m1_req,
    output logic o_m0_gnt,
    output logic o_m1_gnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic       w_force_m1;

    // M1 is forced once M0 has won LIMIT times in a row while M1 waited.
    assign w_force_m1 = (r_starve_cnt == LIMIT) && i_m1_req;

    // Grants are gated by reset so nothing reaches the I/O block while
    // reset is held (a UART read would otherwise lose a character).
    always_comb begin
        o_m0_gnt = 1'b0;
        o_m1_gnt = 1'b0;
        if (i_rst_n) begin
            if (w_force_m1) begin
                o_m1_gnt = 1'b1;
            end else if (i_m0_req) begin
                o_m0_gnt = 1'b1;
            end else if (i_m1_req) begin
                o_m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (o_m1_gnt || !i_m1_req) begin
            w_starve_nxt = 4'd0;
        end else if (o_m0_gnt && (r_starve_cnt != LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

endmodule

// File: rtl/ramio_arbiter.sv
// Shares data port A of the RAM/UART/LED I/O block between M0 (CPU
// load/store unit, fixed priority) and M1 (DMA / UART boot loader), with a
// starvation counter that forces an M1 grant after STARVE_LIMIT M0 wins.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   m0_req/we/re/addr/din         M0 request fields (held until m0_gnt)
//   m0_gnt, m0_rvalid             combinational grant, registered read valid
//   m1_*                          identical set for M1
//   rdata                         ram_dout passed through, qualified by mX_rvalid
//   ram_we/re/addr/din            to I/O block port A
//   ram_dout                      from I/O block, valid one cycle after a read
module ramio_arbiter
    import ramio_pkg::*;
#(
    parameter int ADDR_WIDTH   = RAMIO_ADDR_WIDTH,
    parameter int DATA_WIDTH   = RAMIO_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = byte_addr_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [1:0]            m0_we,
    input  logic [2:0]            m0_re,
    input  logic [AW-1:0]         m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,

    input  logic                  m1_req,
    input  logic [1:0]            m1_we,
    input  logic [2:0]            m1_re,
    input  logic [AW-1:0]         m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic [1:0]            ram_we,
    output logic [2:0]            ram_re,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic w_m0_gnt;
    logic w_m1_gnt;
    logic w_m0_rd;
    logic w_m1_rd;
    logic r_m0_rvalid;
    logic r_m1_rvalid;

    ramio_arb_core #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_core (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_m0_req (m0_req),
        .i_m1_req (m1_req),
        .o_m0_gnt (w_m0_gnt),
        .o_m1_gnt (w_m1_gnt)
    );

    // A request carrying both we and re is treated as a write only: the read
    // half is suppressed so no side-effecting read reaches the I/O block.
    assign w_m0_rd = (m0_we == WE_NONE) && (m0_re[1:0] != RE_NONE);
    assign w_m1_rd = (m1_we == WE_NONE) && (m1_re[1:0] != RE_NONE);

    always_comb begin
        ram_we   = WE_NONE;
        ram_re   = 3'b000;
        ram_addr = '0;
        ram_din  = '0;
        if (w_m0_gnt) begin
            ram_we   = m0_we;
            ram_re   = w_m0_rd ? m0_re : 3'b000;
            ram_addr = m0_addr;
            ram_din  = m0_din;
        end else if (w_m1_gnt) begin
            ram_we   = m1_we;
            ram_re   = w_m1_rd ? m1_re : 3'b000;
            ram_addr = m1_addr;
            ram_din  = m1_din;
        end
    end

    // Read valid tracks the I/O block's one-cycle read latency; reset drops
    // any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_m0_gnt && w_m0_rd;
            r_m1_rvalid <= w_m1_gnt && w_m1_rd;
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign rdata     = ram_dout;

endmodule

// File: tb/tb_ramio_arbiter.sv
module tb_ramio_arbiter;

    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          m0_req, m1_req;
    logic [1:0]    m0_we, m1_we;
    logic [2:0]    m0_re, m1_re;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_din, m1_din;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    ram_we;
    logic [2:0]    ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_checks;
    int n_errors;

    ramio_arbiter #(
        .ADDR_WIDTH   (16),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_re     (m0_re),
        .m0_addr   (m0_addr),
        .m0_din    (m0_din),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_re     (m1_re),
        .m1_addr   (m1_addr),
        .m1_din    (m1_din),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- I/O block model (byte RAM, 1-cycle read) ----------------
    logic [7:0] mem [4096];

    function automatic logic [31:0] mem_read(input logic [2:0] re, input logic [11:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[a];
        h = {mem[a + 12'd1], mem[a]};
        case (re[1:0])
            2'b01:   return re[2] ? {{24{b[7]}}, b} : {24'b0, b};
            2'b10:   return re[2] ? {{16{h[15]}}, h} : {16'b0, h};
            2'b11:   return {mem[a + 12'd3], mem[a + 12'd2], h};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        case (ram_we)
            2'b01: mem[ram_addr[11:0]] <= ram_din[7:0];
            2'b10: begin
                mem[ram_addr[11:0]]         <= ram_din[7:0];
                mem[ram_addr[11:0] + 12'd1] <= ram_din[15:8];
            end
            2'b11: begin
                mem[ram_addr[11:0]]         <= ram_din[7:0];
                mem[ram_addr[11:0] + 12'd1] <= ram_din[15:8];
                mem[ram_addr[11:0] + 12'd2] <= ram_din[23:16];
                mem[ram_addr[11:0] + 12'd3] <= ram_din[31:24];
            end
            default: ;
        endcase
        if (ram_re[1:0] != 2'b00) ram_dout <= mem_read(ram_re, ram_addr[11:0]);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_m0(input logic req, input logic [1:0] we, input logic [2:0] re,
                            input logic [AW-1:0] addr, input logic [DW-1:0] din);
        m0_req = req; m0_we = we; m0_re = re; m0_addr = addr; m0_din = din;
    endtask

    task automatic drive_m1(input logic req, input logic [1:0] we, input logic [2:0] re,
                            input logic [AW-1:0] addr, input logic [DW-1:0] din);
        m1_req = req; m1_we = we; m1_re = re; m1_addr = addr; m1_din = din;
    endtask

    task automatic drive_idle();
        drive_m0(1'b0, 2'b00, 3'b000, '0, '0);
        drive_m1(1'b0, 2'b00, 3'b000, '0, '0);
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        ram_dout = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // 1. Reset with both masters requesting reads
        rst = 1'b0;
        drive_m0(1'b1, 2'b00, 3'b011, 18'h100, '0);
        drive_m1(1'b1, 2'b00, 3'b011, 18'h104, '0);
        #2;
        check_eq("rst m0_gnt", {31'b0, m0_gnt}, 0);
        check_eq("rst m1_gnt", {31'b0, m1_gnt}, 0);
        check_eq("rst ram_we", {30'b0, ram_we}, 0);
        check_eq("rst ram_re", {29'b0, ram_re}, 0);
        @(posedge clk); #1;
        check_eq("rst m0_rvalid", {31'b0, m0_rvalid}, 0);
        check_eq("rst m1_rvalid", {31'b0, m1_rvalid}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("post-rst m0_gnt", {31'b0, m0_gnt}, 1);
        check_eq("post-rst m1_gnt", {31'b0, m1_gnt}, 0);
        check_eq("post-rst ram_re", {29'b0, ram_re}, 32'h3);
        @(posedge clk); #1;
        check_eq("post-rst m0_rvalid", {31'b0, m0_rvalid}, 1);

        // 2. M0 only: sw then lw
        @(negedge clk);
        drive_idle();
        drive_m0(1'b1, 2'b11, 3'b000, 18'h100, 32'h1234ABCD);
        #1;
        check_eq("sw m0_gnt", {31'b0, m0_gnt}, 1);
        check_eq("sw ram_we", {30'b0, ram_we}, 32'h3);
        check_eq("sw ram_addr", {14'b0, ram_addr}, 32'h100);
        check_eq("sw ram_din", ram_din, 32'h1234ABCD);
        @(posedge clk); #1;
        check_eq("sw m0_rvalid", {31'b0, m0_rvalid}, 0);
        @(negedge clk);
        drive_m0(1'b1, 2'b00, 3'b011, 18'h100, '0);
        #1;
        check_eq("lw m0_gnt", {31'b0, m0_gnt}, 1);
        check_eq("lw ram_re", {29'b0, ram_re}, 32'h3);
        @(posedge clk); #1;
        check_eq("lw m0_rvalid", {31'b0, m0_rvalid}, 1);
        check_eq("lw rdata", rdata, 32'h1234ABCD);
        @(negedge clk);
        drive_m0(1'b1, 2'b11, 3'b000, 18'h000, 32'h80117F22);
        #1;
        check_eq("sw2 m0_gnt", {31'b0, m0_gnt}, 1);
        @(posedge clk); #1;
        check_eq("sw2 m0_rvalid", {31'b0, m0_rvalid}, 0);
        @(negedge clk);
        drive_idle();
        #1;
        check_eq("idle ram_we", {30'b0, ram_we}, 0);
        check_eq("idle ram_re", {29'b0, ram_re}, 0);
        check_eq("idle ram_addr", {14'b0, ram_addr}, 0);
        check_eq("idle gnt", {30'b0, m1_gnt, m0_gnt}, 0);

        // 3. Continuous contention: M0 x4 then forced M1
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_m0(1'b1, 2'b00, 3'b000, '0, '0);
            drive_m1(1'b1, 2'b00, 3'b000, '0, '0);
            #1;
            check_eq($sformatf("starve[%0d] gnt", i), {30'b0, m1_gnt, m0_gnt},
                     (i % 5 == 4) ? 32'h2 : 32'h1);
        end

        // 4. Back-to-back: M0 lb @3, then M1 lhu @2
        @(negedge clk);
        drive_idle();
        drive_m0(1'b1, 2'b00, 3'b101, 18'h003, '0);
        #1;
        check_eq("lb m0_gnt", {31'b0, m0_gnt}, 1);
        @(posedge clk); #1;
        check_eq("lb m0_rvalid", {31'b0, m0_rvalid}, 1);
        check_eq("lb m1_rvalid", {31'b0, m1_rvalid}, 0);
        check_eq("lb rdata", rdata, 32'hFFFFFF80);
        @(negedge clk);
        drive_idle();
        drive_m1(1'b1, 2'b00, 3'b010, 18'h002, '0);
        #1;
        check_eq("lhu m1_gnt", {31'b0, m1_gnt}, 1);
        check_eq("lhu ram_re overlap", {29'b0, ram_re}, 32'h2);
        check_eq("lhu m0_rvalid overlap", {31'b0, m0_rvalid}, 1);
        @(posedge clk); #1;
        check_eq("lhu m1_rvalid", {31'b0, m1_rvalid}, 1);
        check_eq("lhu m0_rvalid", {31'b0, m0_rvalid}, 0);
        check_eq("lhu rdata", rdata, 32'h00008011);

        // 5. Illegal we+re from M1, then read back via M0
        @(negedge clk);
        drive_idle();
        drive_m1(1'b1, 2'b01, 3'b001, 18'h200, 32'h0000005A);
        #1;
        check_eq("illegal m1_gnt", {31'b0, m1_gnt}, 1);
        check_eq("illegal ram_we", {30'b0, ram_we}, 32'h1);
        check_eq("illegal ram_re", {29'b0, ram_re}, 0);
        @(posedge clk); #1;
        check_eq("illegal m1_rvalid", {31'b0, m1_rvalid}, 0);
        @(negedge clk);
        drive_idle();
        drive_m1(1'b1, 2'b00, 3'b000, 18'h204, '0);
        #1;
        check_eq("noop m1_gnt", {31'b0, m1_gnt}, 1);
        @(posedge clk); #1;
        check_eq("noop m1_rvalid", {31'b0, m1_rvalid}, 0);
        @(negedge clk);
        drive_idle();
        drive_m0(1'b1, 2'b00, 3'b011, 18'h200, '0);
        @(posedge clk); #1;
        check_eq("readback m0_rvalid", {31'b0, m0_rvalid}, 1);
        check_eq("readback rdata", rdata, 32'h0000005A);

        // 6. Reset asserted the cycle after an M0 lw grant
        @(negedge clk);
        drive_idle();
        drive_m0(1'b1, 2'b00, 3'b011, 18'h100, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        #1;
        check_eq("midrd m0_rvalid", {31'b0, m0_rvalid}, 0);
        @(posedge clk); #1;
        check_eq("midrd held m0_rvalid", {31'b0, m0_rvalid}, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            drive_m0(1'b1, 2'b00, 3'b000, '0, '0);
            drive_m1(1'b1, 2'b00, 3'b000, '0, '0);
            #1;
            check_eq($sformatf("post-midrd[%0d] gnt", i), {30'b0, m1_gnt, m0_gnt},
                     (i == 4) ? 32'h2 : 32'h1);
        end

        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
